int_add_rr_sched: RTL and testbench

INT_ADD_RR_SCHED -- requirements
Module: int_add_rr_sched

---
 rtl/int_add_rr_sched.sv | 142 ++++++++++++++
 tb/tb_int_add_rr_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_add_rr_sched.sv
// Round-robin front end that shares one external adder among NUM_REQ requesters.
// Each requester has at most one operation in flight. Its result is parked in a
// per-requester register until the requester consumes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. Request side: req_ready[i] is a combinational grant and is never high
// unless req_valid[i] is high. Response side: rsp_valid[t] holds, with rsp_c[t]
// held steady, until an edge where rsp_ready[t] is high.
//
// Adder timing: operands launched in cycle k must produce their sum on add_c
// during cycle k+ADD_LATENCY-1. With ADD_LATENCY=1 the adder is purely
// combinational. The result is captured at the end of that cycle, so rsp_valid
// rises ADD_LATENCY cycles after the issue cycle.
module int_add_rr_sched #(
    parameter int OP_BITWIDTH = 32,
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*OP_BITWIDTH-1:0] req_a,
    input  logic [NUM_REQ*OP_BITWIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]             req_apx,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [NUM_REQ*OP_BITWIDTH-1:0] rsp_c,
    output logic [OP_BITWIDTH-1:0]         add_a,
    output logic [OP_BITWIDTH-1:0]         add_b,
    output logic                           add_apx_ctl,
    input  logic [OP_BITWIDTH-1:0]         add_c,
    output logic                           busy
);

    localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Register stages in the tag pipeline. Stage 0 of the logical pipeline is
    // the combinational issue itself, so only ADD_LATENCY-1 stages need flops.
    localparam int PD = (ADD_LATENCY > 1) ? ADD_LATENCY - 1 : 1;

    logic [NUM_REQ-1:0]             outstanding_q, outstanding_d;
    logic [TW-1:0]                  ptr_q, ptr_d;
    logic [PD-1:0]                  pv_q, pv_d;
    logic [PD-1:0][TW-1:0]          pt_q, pt_d;
    logic [NUM_REQ-1:0]             rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ*OP_BITWIDTH-1:0] rsp_c_q, rsp_c_d;

    logic [NUM_REQ-1:0] elig;
    logic               grant_vld;
    logic [TW-1:0]      grant_idx;
    int                 cand;
    logic               ret_valid;
    logic [TW-1:0]      ret_tag;

    // Round-robin search starting at ptr. Requesters with work outstanding are
    // skipped, and the async reset gates every grant.
    always_comb begin
        elig      = req_valid & ~outstanding_q & {NUM_REQ{rst}};
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!grant_vld && elig[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand[TW-1:0];
            end
        end
    end

    // Grant outputs and adder operand mux. The bus reads zero when idle.
    always_comb begin
        req_ready   = '0;
        add_a       = '0;
        add_b       = '0;
        add_apx_ctl = 1'b0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
            add_a                = req_a[grant_idx*OP_BITWIDTH +: OP_BITWIDTH];
            add_b                = req_b[grant_idx*OP_BITWIDTH +: OP_BITWIDTH];
            add_apx_ctl          = req_apx[grant_idx];
        end
    end

    // Next state: pointer advance, tag pipeline shift, result capture and consume.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + TW'(1);
        end

        pv_d    = '0;
        pt_d    = '0;
        pv_d[0] = grant_vld;
        pt_d[0] = grant_idx;
        for (int s = 1; s < PD; s++) begin
            pv_d[s] = pv_q[s-1];
            pt_d[s] = pt_q[s-1];
        end

        ret_valid = (ADD_LATENCY == 1) ? grant_vld : pv_q[PD-1];
        ret_tag   = (ADD_LATENCY == 1) ? grant_idx : pt_q[PD-1];

        outstanding_d = outstanding_q & ~(rsp_valid_q & rsp_ready);
        rsp_valid_d   = rsp_valid_q & ~rsp_ready;
        rsp_c_d       = rsp_c_q;
        if (grant_vld) begin
            outstanding_d[grant_idx] = 1'b1;
        end
        // A return never lands on an unconsumed result. The outstanding flag
        // blocks reissue until the previous result has been taken.
        if (ret_valid) begin
            rsp_valid_d[ret_tag]                          = 1'b1;
            rsp_c_d[ret_tag*OP_BITWIDTH +: OP_BITWIDTH]   = add_c;
        end
    end

    // State registers. Reset discards everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding_q <= '0;
            ptr_q         <= '0;
            pv_q          <= '0;
            pt_q          <= '0;
            rsp_valid_q   <= '0;
            rsp_c_q       <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            ptr_q         <= ptr_d;
            pv_q          <= pv_d;
            pt_q          <= pt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_c_q       <= rsp_c_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_c     = rsp_c_q;
    // Outstanding covers both operations in the adder and parked results.
    assign busy      = |outstanding_q;

endmodule

// File: tb/tb_int_add_rr_sched.sv
// Directed bench for int_add_rr_sched. One instance uses a combinational
// adder (ADD_LATENCY=1). A second instance uses a two-register adder
// (ADD_LATENCY=3) and is used to check latency and mid-flight reset.
module tb_int_add_rr_sched;
    localparam int W = 32;
    localparam int N = 4;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, rst3;

    // Instance with a combinational adder
    logic [N-1:0]   rv1, rr1, apx1, rdy1, rspv1;
    logic [N*W-1:0] a1, b1, c1;
    logic [W-1:0]   adda1, addb1, addc1;
    logic           addapx1, busy1;
    assign addc1 = adda1 + addb1;

    int_add_rr_sched #(.OP_BITWIDTH(W), .NUM_REQ(N), .ADD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(rv1), .req_ready(rdy1), .req_a(a1), .req_b(b1), .req_apx(apx1),
        .rsp_valid(rspv1), .rsp_ready(rr1), .rsp_c(c1),
        .add_a(adda1), .add_b(addb1), .add_apx_ctl(addapx1), .add_c(addc1),
        .busy(busy1)
    );

    // Instance with a three-cycle adder (two registers after launch)
    logic [N-1:0]   rv3, rr3, apx3, rdy3, rspv3;
    logic [N*W-1:0] a3, b3, c3;
    logic [W-1:0]   adda3, addb3, addc3;
    logic           addapx3, busy3;
    logic [W-1:0]   s1 = '0;
    logic [W-1:0]   s2 = '0;
    always @(posedge clk) begin
        s1 <= adda3 + addb3;
        s2 <= s1;
    end
    assign addc3 = s2;

    int_add_rr_sched #(.OP_BITWIDTH(W), .NUM_REQ(N), .ADD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst3),
        .req_valid(rv3), .req_ready(rdy3), .req_a(a3), .req_b(b3), .req_apx(apx3),
        .rsp_valid(rspv3), .rsp_ready(rr3), .rsp_c(c3),
        .add_a(adda3), .add_b(addb3), .add_apx_ctl(addapx3), .add_c(addc3),
        .busy(busy3)
    );

    // Checking
    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] sl(input logic [N*W-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    // Driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_op1(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a1[i*W +: W] = a;
        b1[i*W +: W] = b;
    endtask

    task automatic set_op3(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a3[i*W +: W] = a;
        b3[i*W +: W] = b;
    endtask

    int bp_seq [10] = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3};

    initial begin
        rst = 1'b0; rst3 = 1'b0;
        rv1 = '0; rr1 = '0; apx1 = '0; a1 = '0; b1 = '0;
        rv3 = '0; rr3 = '0; apx3 = '0; a3 = '0; b3 = '0;
        tick();
        // Reset state, with requests pending and operands on the inputs
        rv1 = 4'b1111; apx1 = 4'b1111; set_op1(0, 32'd9, 32'd9);
        settle();
        chk("rst_ready", rdy1, 0);
        chk("rst_rspv", rspv1, 0);
        chk("rst_rspc", c1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_adda", adda1, 0);
        chk("rst_apx", addapx1, 0);
        tick();
        rv1 = '0; apx1 = '0;
        rst = 1'b1; rst3 = 1'b1;
        tick();

        // Single issue: 5 + 7 with approximation requested
        rv1 = 4'b0001; set_op1(0, 32'd5, 32'd7); apx1 = 4'b0001; rr1 = '0;
        settle();
        chk("single_ready", rdy1, 4'b0001);
        chk("single_adda", adda1, 5);
        chk("single_addb", addb1, 7);
        chk("single_apx", addapx1, 1);
        tick();
        chk("single_rspv", rspv1, 4'b0001);
        chk("single_rspc", sl(c1, 0), 12);
        chk("single_busy", busy1, 1);
        rr1 = 4'b0001;
        settle();
        chk("no_reissue", rdy1, 0);
        tick();
        chk("consumed", rspv1, 0);
        rr1 = '0;
        settle();
        chk("reissue_next", rdy1, 4'b0001);
        tick();
        chk("reissue_rspv", rspv1, 4'b0001);
        rv1 = '0; rr1 = 4'b0001;
        tick();
        rr1 = '0;
        settle();
        chk("idle_rspv", rspv1, 0);
        chk("idle_busy", busy1, 0);
        chk("idle_adda", adda1, 0);
        chk("idle_apx", addapx1, 0);
        apx1 = '0;

        // Reset pulse so the pointer starts from 0 for the fairness run
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Fairness: all four requesting, all results consumed at once
        for (int i = 0; i < N; i++) set_op1(i, 100 + i, 10 * i);
        rv1 = 4'b1111; rr1 = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            settle();
            if (k > 0) begin
                chk("fair_rspv", rspv1, 64'd1 << ((k - 1) % 4));
                chk("fair_rspc", sl(c1, (k - 1) % 4), 100 + 11 * ((k - 1) % 4));
            end
            chk("fair_grant", rdy1, 64'd1 << (k % 4));
            chk("fair_adda", adda1, 100 + (k % 4));
            tick();
        end
        rv1 = '0;
        chk("fair_last_rspv", rspv1, 4'b1000);
        tick();
        chk("fair_drain", rspv1, 0);
        chk("fair_busy", busy1, 0);

        // Backpressure: requester 2 never consumes its result
        rv1 = 4'b1111; rr1 = 4'b1011;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) set_op1(2, 32'd999, 32'd1);
            settle();
            chk("bp_grant", rdy1, 64'd1 << bp_seq[k]);
            if (k >= 3) begin
                chk("bp_rspv2", rspv1[2], 1);
                chk("bp_rspc2", sl(c1, 2), 122);
            end
            tick();
        end
        rv1 = '0; rr1 = 4'b1111;
        tick();
        chk("bp_drain", rspv1, 0);
        chk("bp_busy", busy1, 0);
        set_op1(2, 32'd102, 32'd20);

        // Wrap: move the pointer to 3 with a lone grant to 2
        rv1 = 4'b0100;
        settle();
        chk("wrap_setup", rdy1, 4'b0100);
        tick();
        rv1 = 4'b1001;
        settle();
        chk("wrap_first", rdy1, 4'b1000);
        tick();
        settle();
        chk("wrap_second", rdy1, 4'b0001);
        tick();
        rv1 = '0;
        tick();
        rv1 = 4'b1111;
        settle();
        chk("wrap_ptr", rdy1, 4'b0010);
        tick();
        rv1 = '0;
        tick();
        tick();
        chk("wrap_busy", busy1, 0);

        // Signed edge values through the exact adder, pointer now at 2
        set_op1(0, 32'hFFFF_FFFF, 32'd1);
        set_op1(1, 32'h7FFF_FFFF, 32'd1);
        rr1 = '0; rv1 = 4'b0011;
        settle();
        chk("neg_grant0", rdy1, 4'b0001);
        chk("neg_adda", adda1, 32'hFFFF_FFFF);
        tick();
        settle();
        chk("neg_rspv0", rspv1, 4'b0001);
        chk("neg_rspc0", sl(c1, 0), 0);
        chk("neg_grant1", rdy1, 4'b0010);
        tick();
        rv1 = '0;
        chk("neg_rspv01", rspv1, 4'b0011);
        chk("neg_rspc1", sl(c1, 1), 32'h8000_0000);
        chk("neg_rspc0_hold", sl(c1, 0), 0);
        rr1 = 4'b1111;
        tick();
        tick();
        chk("neg_busy", busy1, 0);

        // Three-cycle adder: latency check on requester 2 (20 + 22)
        rv3 = 4'b0100; set_op3(2, 32'd20, 32'd22); rr3 = '0;
        settle();
        chk("lat3_grant", rdy3, 4'b0100);
        tick();
        rv3 = '0;
        chk("lat3_c1", rspv3, 0);
        tick();
        chk("lat3_c2", rspv3, 0);
        tick();
        chk("lat3_rspv", rspv3, 4'b0100);
        chk("lat3_rspc", sl(c3, 2), 42);
        rr3 = 4'b0100;
        tick();
        rr3 = '0;
        chk("lat3_drain", rspv3, 0);
        chk("lat3_busy", busy3, 0);

        // Mid-flight reset: issue to 0 and 1, then one cycle of reset
        set_op3(0, 32'd1, 32'd2);
        set_op3(1, 32'd3, 32'd4);
        rv3 = 4'b0011;
        settle();
        chk("mid_grant0", rdy3, 4'b0001);
        tick();
        settle();
        chk("mid_grant1", rdy3, 4'b0010);
        tick();
        rv3 = '0;
        chk("mid_pre_rspv", rspv3, 0);
        chk("mid_pre_busy", busy3, 1);
        rst3 = 1'b0;
        settle();
        chk("mid_rst_ready", rdy3, 0);
        chk("mid_rst_rspv", rspv3, 0);
        chk("mid_rst_rspc", c3, 0);
        chk("mid_rst_busy", busy3, 0);
        chk("mid_rst_adda", adda3, 0);
        tick();
        rst3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("mid_quiet_rspv", rspv3, 0);
            chk("mid_quiet_rspc", c3, 0);
            tick();
        end
        // First grant after release searches from index 0
        rv3 = 4'b1010;
        settle();
        chk("mid_restart", rdy3, 4'b0010);
        tick();
        rv3 = '0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
